// File: rtl/clk_gating_pkg.sv
// Shared clock-gating types: FSM state encoding and counter sizing helper.
package clk_gating_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } cg_state_t;

  function automatic int cg_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Control/status bundle between requesters and the clock-gate enable controller.
interface clk_gate_ctrl_if;
  logic activity;
  logic force_on;
  logic wake_req;
  logic gate_en;
  logic wake_ack;
  logic gated;

  modport master (
    output activity, force_on, wake_req,
    input  gate_en, wake_ack, gated
  );

  modport slave (
    input  activity, force_on, wake_req,
    output gate_en, wake_ack, gated
  );
endinterface

// File: rtl/clk_gate_top.sv
// Integration wrapper: enable controller feeding the ICG.
module clk_gate_top #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  clk_gate_ctrl_if.slave  bus,
  output logic            gclk_o
);

  clk_gate_ctrl #(
    .IDLE_CYCLES(IDLE_CYCLES),
    .WAKE_CYCLES(WAKE_CYCLES)
  ) u_ctrl (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  clk_gating u_icg (
    .clk    (clk),
    .en_i   (bus.gate_en),
    .gclk_o (gclk_o)
  );

endmodule

// File: rtl/clk_gating.sv
// Latch-based integrated clock gate: enable captured while clk is low.
module clk_gating (
  input  logic clk,
  input  logic en_i,
  output logic gclk_o
);
  logic en_lat;

  // Transparent while clk low so the AND never sees en change mid high phase.
  always_latch begin
    if (!clk) en_lat <= en_i;
  end

  assign gclk_o = clk & en_lat;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Enable generator for the latch-based ICG: gates after an idle window,
// ungates on wake source with a fixed settle period and a req/ack handshake.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_RUN   | clock running, watching for the first idle cycle
//   ST_IDLE  | clock running, counting consecutive idle cycles
//   ST_GATED | clock stopped (gate_en=0), waiting for a wake source
//   ST_WAKE  | clock restarted, settling before RUN / wake_ack
module clk_gate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  clk_gate_ctrl_if.slave  bus
);
  import clk_gating_pkg::*;

  localparam int CW = $clog2(cg_max(IDLE_CYCLES, WAKE_CYCLES) + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);

  cg_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ack_done_q, ack_done_d;
  logic            gate_en_q, gate_en_d;
  logic            wake_ack_q, wake_ack_d;
  logic            gated_q, gated_d;
  logic            ws;

  // Next state, counter, handshake and Moore outputs decoded from next state.
  always_comb begin
    ws         = bus.wake_req | bus.force_on | bus.activity;
    state_d    = state_q;
    cnt_d      = cnt_q;
    wake_ack_d = 1'b0;
    ack_done_d = ack_done_q;

    case (state_q)
      ST_RUN: begin
        if (!ws) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          wake_ack_d = bus.wake_req & ~ack_done_q;
        end
      end
      ST_IDLE: begin
        cnt_d = cnt_q + CW'(1);
        // A wake source in the terminal cycle still wins over gating.
        if (ws) begin
          state_d    = ST_RUN;
          cnt_d      = '0;
          wake_ack_d = bus.wake_req & ~ack_done_q;
        end else if (cnt_q == IDLE_LAST) begin
          state_d = ST_GATED;
          cnt_d   = '0;
        end
      end
      ST_GATED: begin
        if (ws) begin
          state_d = ST_WAKE;
          cnt_d   = '0;
        end
      end
      ST_WAKE: begin
        // Runs to completion regardless of wake-source changes.
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == WAKE_LAST) begin
          state_d    = ST_RUN;
          cnt_d      = '0;
          wake_ack_d = bus.wake_req & ~ack_done_q;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase

    // One ack per wake_req assertion; re-armed once wake_req is seen low.
    if (wake_ack_d)
      ack_done_d = 1'b1;
    else if (!bus.wake_req)
      ack_done_d = 1'b0;

    gate_en_d = (state_d != ST_GATED);
    gated_d   = (state_d == ST_GATED);
  end

  // State and registered outputs; reset leaves the clock ungated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      ack_done_q <= 1'b0;
      gate_en_q  <= 1'b1;
      wake_ack_q <= 1'b0;
      gated_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_done_q <= ack_done_d;
      gate_en_q  <= gate_en_d;
      wake_ack_q <= wake_ack_d;
      gated_q    <= gated_d;
    end
  end

  assign bus.gate_en  = gate_en_q;
  assign bus.wake_ack = wake_ack_q;
  assign bus.gated    = gated_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl plus a gated-clock pulse-width check on clk_gate_top.
module tb_clk_gate_ctrl;

  logic clk;
  logic rst;
  logic gclk2;
  int   n_tests;
  int   n_fail;
  int   suppressed;
  bit   mon_en;
  longint rise_t;

  clk_gate_ctrl_if ifc();
  clk_gate_ctrl_if ifc2();

  clk_gate_ctrl #(.IDLE_CYCLES(16), .WAKE_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  clk_gate_top #(.IDLE_CYCLES(1), .WAKE_CYCLES(1)) u_top (
    .clk    (clk),
    .rst    (rst),
    .bus    (ifc2),
    .gclk_o (gclk2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gated();
    int n;
    n = 0;
    while (!ifc.gated && n < 40) begin
      tick();
      n++;
    end
    check_eq("wait_gated", 32'(ifc.gated), 1);
  endtask

  // Every gated-clock high pulse must span the full clk high phase.
  always @(posedge gclk2) rise_t = $time;
  always @(negedge gclk2) begin
    if (mon_en) check_eq("gclk_width", 32'($time - rise_t), 5);
  end

  initial begin
    n_tests = 0;
    n_fail = 0;
    suppressed = 0;
    mon_en = 1'b0;
    rise_t = 0;
    rst = 1'b1;
    ifc.activity = 1'b1; ifc.force_on = 1'b0; ifc.wake_req = 1'b0;
    ifc2.activity = 1'b1; ifc2.force_on = 1'b0; ifc2.wake_req = 1'b0;

    // reset values before any clock edge
    #3;
    check_eq("rst_gate_en", 32'(ifc.gate_en), 1);
    check_eq("rst_wake_ack", 32'(ifc.wake_ack), 0);
    check_eq("rst_gated", 32'(ifc.gated), 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check_eq("run_gate_en", 32'(ifc.gate_en), 1);
    check_eq("run_gated", 32'(ifc.gated), 0);

    // idle gating: activity low after edge 0, gated after edge 17
    ifc.activity = 1'b0;
    repeat (16) tick();
    check_eq("idle16_gated", 32'(ifc.gated), 0);
    check_eq("idle16_gate_en", 32'(ifc.gate_en), 1);
    tick();
    check_eq("idle17_gated", 32'(ifc.gated), 1);
    check_eq("idle17_gate_en", 32'(ifc.gate_en), 0);

    // asynchronous reset while gated, mid clk-high
    #2 rst = 1'b1;
    #1;
    check_eq("arst_gate_en", 32'(ifc.gate_en), 1);
    check_eq("arst_gated", 32'(ifc.gated), 0);
    ifc.activity = 1'b1;
    #1 rst = 1'b0;
    tick(); tick();
    check_eq("arst_run_gate_en", 32'(ifc.gate_en), 1);

    // activity pulse at edge 10 restarts the idle count
    ifc.activity = 1'b0;
    repeat (9) tick();
    ifc.activity = 1'b1;
    tick();
    check_eq("pulse_gated", 32'(ifc.gated), 0);
    ifc.activity = 1'b0;
    tick();
    repeat (15) tick();
    check_eq("restart_early_gated", 32'(ifc.gated), 0);
    tick();
    check_eq("restart_gated", 32'(ifc.gated), 1);

    // wake from gated: gate_en after k, ack after k+2, single ack
    ifc.wake_req = 1'b1;
    tick();
    check_eq("wk_gate_en", 32'(ifc.gate_en), 1);
    check_eq("wk_gated", 32'(ifc.gated), 0);
    check_eq("wk_ack_k", 32'(ifc.wake_ack), 0);
    tick();
    check_eq("wk_ack_k1", 32'(ifc.wake_ack), 0);
    tick();
    check_eq("wk_ack_k2", 32'(ifc.wake_ack), 1);
    tick();
    check_eq("wk_ack_hold", 32'(ifc.wake_ack), 0);
    ifc.wake_req = 1'b0;
    tick();
    check_eq("wk_ack_drop", 32'(ifc.wake_ack), 0);

    // collision: wake_req sampled while IDLE cnt=15
    repeat (15) tick();
    check_eq("col_pre_gated", 32'(ifc.gated), 0);
    ifc.wake_req = 1'b1;
    tick();
    check_eq("col_ack", 32'(ifc.wake_ack), 1);
    check_eq("col_gated", 32'(ifc.gated), 0);
    check_eq("col_gate_en", 32'(ifc.gate_en), 1);
    ifc.wake_req = 1'b0;
    tick();
    check_eq("col_ack_single", 32'(ifc.wake_ack), 0);
    check_eq("col_after_gated", 32'(ifc.gated), 0);

    // force_on held 100 cycles keeps the clock ungated
    ifc.force_on = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check_eq("fo_gate_en", 32'(ifc.gate_en), 1);
    end
    ifc.force_on = 1'b0;
    repeat (16) tick();
    check_eq("fo_drop16_gated", 32'(ifc.gated), 0);
    tick();
    check_eq("fo_drop17_gated", 32'(ifc.gated), 1);

    // force_on raised while gated: wake sequence, no ack
    ifc.force_on = 1'b1;
    tick();
    check_eq("fg_gate_en", 32'(ifc.gate_en), 1);
    tick(); tick();
    check_eq("fg_ack", 32'(ifc.wake_ack), 0);
    tick();
    check_eq("fg_gated", 32'(ifc.gated), 0);
    ifc.force_on = 1'b0;

    // wake_req dropped inside WAKE: wake completes, no ack
    wait_gated();
    ifc.wake_req = 1'b1;
    tick();
    ifc.wake_req = 1'b0;
    tick(); tick();
    check_eq("wd_ack", 32'(ifc.wake_ack), 0);
    check_eq("wd_gate_en", 32'(ifc.gate_en), 1);
    tick();
    check_eq("wd_ack2", 32'(ifc.wake_ack), 0);

    // asynchronous reset mid-WAKE
    wait_gated();
    ifc.activity = 1'b1;
    tick();
    #2 rst = 1'b1;
    #1;
    check_eq("rw_gate_en", 32'(ifc.gate_en), 1);
    check_eq("rw_ack", 32'(ifc.wake_ack), 0);
    check_eq("rw_gated", 32'(ifc.gated), 0);
    #1 rst = 1'b0;
    tick();
    check_eq("rw_run_gate_en", 32'(ifc.gate_en), 1);

    // IDLE_CYCLES=1 / WAKE_CYCLES=1 corner on the wrapper
    ifc2.activity = 1'b0;
    tick();
    check_eq("c1_idle_gated", 32'(ifc2.gated), 0);
    tick();
    check_eq("c1_gated", 32'(ifc2.gated), 1);
    ifc2.wake_req = 1'b1;
    tick();
    check_eq("c1_wake_gate_en", 32'(ifc2.gate_en), 1);
    check_eq("c1_wake_ack0", 32'(ifc2.wake_ack), 0);
    tick();
    check_eq("c1_wake_ack1", 32'(ifc2.wake_ack), 1);
    ifc2.wake_req = 1'b0;

    // random wake sources on the wrapper while watching gated-clock pulses
    mon_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!gclk2) suppressed++;
      ifc2.activity = ($urandom_range(0, 7) == 0);
      ifc2.force_on = ($urandom_range(0, 15) == 0);
      ifc2.wake_req = ($urandom_range(0, 9) == 0);
    end
    mon_en = 1'b0;
    check_eq("gclk_suppressed", 32'(suppressed > 0), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
